// File: rtl/uart_rx_fifo.sv
// Oversampled UART receiver with majority-vote bit decisions and a first-word-fall-through receive FIFO.
// Optional line-break detection is built when UART_RX_BREAK_DETECT_EN is defined.
module uart_rx_fifo #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          rx_serial,
  output logic [DATA_BITS-1:0]          rd_data,
  output logic                          rd_frame_err,
  output logic                          rd_parity_err,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clear_errors,
  output logic                          break_detect,
  output logic [3:0]                    db_estado
);

  localparam int DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int DW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TW      = $clog2(OVERSAMPLE);
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CW      = AW + 1;
  localparam int EW      = DATA_BITS + 2;
  localparam int BW      = 4;

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_START  = 4'd1,
    S_DATA   = 4'd2,
    S_PARITY = 4'd3,
    S_STOP   = 4'd4
`ifdef UART_RX_BREAK_DETECT_EN
    ,
    S_BRKWAIT = 4'd5
`endif
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DW-1:0]        r_div_cnt;
  logic                 w_tick;
  logic                 r_sync1;
  logic                 r_sync2;
  logic                 r_rxs_d;
  logic                 w_rxs;
  logic                 w_fall;
  logic [TW-1:0]        r_tick_cnt;
  logic                 r_s0;
  logic                 r_s1;
  logic                 w_samp0;
  logic                 w_samp1;
  logic                 w_decide;
  logic                 w_bit;
  logic [BW-1:0]        r_bit_cnt;
  logic                 w_last_data;
  logic                 w_last_stop;
  logic [DATA_BITS-1:0] r_shift;
  logic                 w_par_ok;
  logic                 r_par_err;
  logic                 r_frame_err;
  logic                 w_push_req;
  logic                 r_push;
  logic [EW-1:0]        r_push_entry;

  // Tick divider free-runs from reset; a tick lasts one clock.
  assign w_tick = (r_div_cnt == DW'(DIV - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= '0;
    end else if (w_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + DW'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_rxs_d <= 1'b1;
    end else begin
      r_sync1 <= rx_serial;
      r_sync2 <= r_sync1;
      r_rxs_d <= r_sync2;
    end
  end

  assign w_rxs  = r_sync2;
  assign w_fall = r_rxs_d & ~w_rxs;

  // Three samples around mid-bit; the third tick is the decision point for the bit.
  assign w_samp0  = w_tick && (r_tick_cnt == TW'(OVERSAMPLE / 2 - 1));
  assign w_samp1  = w_tick && (r_tick_cnt == TW'(OVERSAMPLE / 2));
  assign w_decide = w_tick && (r_tick_cnt == TW'(OVERSAMPLE / 2 + 1));
  assign w_bit    = (r_s0 & r_s1) | (r_s0 & w_rxs) | (r_s1 & w_rxs);

  assign w_last_data = (r_bit_cnt == BW'(DATA_BITS - 1));
  assign w_last_stop = (r_bit_cnt == BW'(STOP_BITS - 1));
  assign w_par_ok    = (PARITY == 1) ? (^r_shift ^ w_bit) : ~(^r_shift ^ w_bit);

`ifdef UART_RX_BREAK_DETECT_EN
  logic r_all_zero;
  logic w_break_req;
  logic r_break;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_all_zero <= 1'b1;
      r_break    <= 1'b0;
    end else begin
      r_break <= w_break_req;
      if (r_state == S_IDLE && w_fall) begin
        r_all_zero <= 1'b1;
      end else if (w_decide && w_bit) begin
        r_all_zero <= 1'b0;
      end
    end
  end

  assign break_detect = r_break;
`else
  assign break_detect = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push_req  = 1'b0;
`ifdef UART_RX_BREAK_DETECT_EN
    w_break_req = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        if (w_fall) w_state_nxt = S_START;
      end
      S_START: begin
        if (w_decide) w_state_nxt = w_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_decide && w_last_data) w_state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_decide) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_decide && w_last_stop) begin
`ifdef UART_RX_BREAK_DETECT_EN
          if (r_all_zero && !w_bit) begin
            w_state_nxt = S_BRKWAIT;
            w_break_req = 1'b1;
          end else begin
            w_state_nxt = S_IDLE;
            w_push_req  = 1'b1;
          end
`else
          w_state_nxt = S_IDLE;
          w_push_req  = 1'b1;
`endif
        end
      end
`ifdef UART_RX_BREAK_DETECT_EN
      S_BRKWAIT: begin
        // Leave only after a full bit time of continuous idle-high line.
        if (w_tick && w_rxs && r_tick_cnt == TW'(OVERSAMPLE - 1)) w_state_nxt = S_IDLE;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign db_estado = r_state;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_tick_cnt   <= '0;
      r_s0         <= 1'b1;
      r_s1         <= 1'b1;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_par_err    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_push       <= 1'b0;
      r_push_entry <= '0;
    end else begin
      r_push <= w_push_req;
      // The final stop bit is folded into the entry directly; r_frame_err lags it by a clock.
      if (w_push_req) r_push_entry <= {r_par_err, r_frame_err | ~w_bit, r_shift};

      if (r_state == S_IDLE && w_fall) begin
        r_tick_cnt <= '0;
`ifdef UART_RX_BREAK_DETECT_EN
      end else if (r_state == S_BRKWAIT && !w_rxs) begin
        r_tick_cnt <= '0;
      end else if (w_break_req) begin
        r_tick_cnt <= '0;
`endif
      end else if (w_tick) begin
        r_tick_cnt <= (r_tick_cnt == TW'(OVERSAMPLE - 1)) ? '0 : r_tick_cnt + TW'(1);
      end

      if (w_samp0) r_s0 <= w_rxs;
      if (w_samp1) r_s1 <= w_rxs;

      if (r_state == S_IDLE && w_fall) begin
        r_bit_cnt   <= '0;
        r_par_err   <= 1'b0;
        r_frame_err <= 1'b0;
      end else if (w_decide) begin
        case (r_state)
          S_DATA: begin
            r_shift   <= {w_bit, r_shift[DATA_BITS-1:1]};
            r_bit_cnt <= w_last_data ? '0 : r_bit_cnt + BW'(1);
          end
          S_PARITY: r_par_err <= ~w_par_ok;
          S_STOP: begin
            r_bit_cnt <= r_bit_cnt + BW'(1);
            if (!w_bit) r_frame_err <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // Read port: rd_valid/rd_data are the registered head; an entry pops on the edge where rd_valid && rd_ready.
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [EW-1:0] r_head;
  logic          r_rd_valid;
  logic          r_overrun;
  logic          w_full;
  logic          w_pop;
  logic          w_wr;
  logic          w_ovf;
  logic [AW-1:0] w_rd_ptr_nxt;
  logic [CW-1:0] w_cnt_after_pop;

  assign w_full          = (r_count == CW'(FIFO_DEPTH));
  assign w_pop           = r_rd_valid & rd_ready;
  assign w_wr            = r_push & (~w_full | w_pop);
  assign w_ovf           = r_push & w_full & ~w_pop;
  assign w_rd_ptr_nxt    = w_pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
  assign w_cnt_after_pop = r_count - CW'(w_pop);

  always_ff @(posedge clock) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_push_entry;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_head     <= '0;
      r_rd_valid <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      r_rd_ptr <= w_rd_ptr_nxt;
      r_count  <= r_count + CW'(w_wr) - CW'(w_pop);
      // A word written this edge reaches the head register one edge later.
      r_rd_valid <= (w_cnt_after_pop != '0);
      if (w_cnt_after_pop != '0) r_head <= r_mem[w_rd_ptr_nxt];
      if (w_ovf) begin
        r_overrun <= 1'b1;
      end else if (clear_errors) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign rd_data       = r_head[DATA_BITS-1:0];
  assign rd_frame_err  = r_head[DATA_BITS];
  assign rd_parity_err = r_head[DATA_BITS+1];
  assign rd_valid      = r_rd_valid;
  assign fifo_count    = r_count;
  assign overrun       = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: 8N1 instance (a) and 8E1 instance (b), both DIV=4, 64 clocks per bit, depth 4.
module tb_uart_rx_fifo;

  localparam int CLK_FREQ = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int BIT_CLKS = 64;
`ifdef UART_RX_BREAK_DETECT_EN
  localparam int EXP_BRK = 1;
`else
  localparam int EXP_BRK = 0;
`endif

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic       rx_a, rx_b;
  logic [7:0] rd_data_a, rd_data_b;
  logic       ferr_a, ferr_b, perr_a, perr_b;
  logic       valid_a, valid_b, ready_a, ready_b;
  logic [2:0] count_a, count_b;
  logic       ovr_a, ovr_b, clr_a, clr_b, brk_a, brk_b;
  logic [3:0] db_a, db_b;

  uart_rx_fifo #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_a (
    .clock(clock), .reset(reset), .rx_serial(rx_a), .rd_data(rd_data_a),
    .rd_frame_err(ferr_a), .rd_parity_err(perr_a), .rd_valid(valid_a), .rd_ready(ready_a),
    .fifo_count(count_a), .overrun(ovr_a), .clear_errors(clr_a), .break_detect(brk_a),
    .db_estado(db_a)
  );

  uart_rx_fifo #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(16), .DATA_BITS(8),
    .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(4)
  ) u_dut_b (
    .clock(clock), .reset(reset), .rx_serial(rx_b), .rd_data(rd_data_b),
    .rd_frame_err(ferr_b), .rd_parity_err(perr_b), .rd_valid(valid_b), .rd_ready(ready_b),
    .fifo_count(count_b), .overrun(ovr_b), .clear_errors(clr_b), .break_detect(brk_b),
    .db_estado(db_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int n_brk_a = 0;
  int n_brk_b = 0;

  // scoreboard: entries are {parity_err, frame_err, data}
  logic [9:0] exp_q_a[$];
  logic [9:0] exp_q_b[$];
  logic [9:0] exp_a, exp_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset && valid_a && ready_a) begin
      if (exp_q_a.size() == 0) begin
        check("rx_a_extra", 32'(0), 32'(1));
      end else begin
        exp_a = exp_q_a.pop_front();
        check("rx_a", 32'({perr_a, ferr_a, rd_data_a}), 32'(exp_a));
      end
    end
    if (reset && valid_b && ready_b) begin
      if (exp_q_b.size() == 0) begin
        check("rx_b_extra", 32'(0), 32'(1));
      end else begin
        exp_b = exp_q_b.pop_front();
        check("rx_b", 32'({perr_b, ferr_b, rd_data_b}), 32'(exp_b));
      end
    end
    if (reset && brk_a) n_brk_a++;
    if (reset && brk_b) n_brk_b++;
  end

  // driver tasks
  task automatic drive_bit(input int sel, input logic v, input int n);
    if (sel == 0) rx_a = v;
    else rx_b = v;
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic flip_par, input logic stop_v);
    drive_bit(sel, 1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], BIT_CLKS);
    if (sel == 1) drive_bit(sel, (^d) ^ flip_par, BIT_CLKS);
    drive_bit(sel, stop_v, BIT_CLKS);
    drive_bit(sel, 1'b1, BIT_CLKS);
  endtask

  task automatic wait_drain(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? exp_q_a.size() : exp_q_b.size()) != 0 && n < 4000) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (sel == 0) check("drain_a", 32'(exp_q_a.size()), 32'(0));
    else check("drain_b", 32'(exp_q_b.size()), 32'(0));
  endtask

  initial begin
    #(10 * 80000);
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rx_a = 1'b1; rx_b = 1'b1;
    ready_a = 1'b1; ready_b = 1'b1;
    clr_a = 1'b0; clr_b = 1'b0;
    repeat (5) @(posedge clock);
    #1;
    check("rst_data", 32'(rd_data_a), 32'(0));
    check("rst_valid", 32'(valid_a), 32'(0));
    check("rst_count", 32'(count_a), 32'(0));
    check("rst_overrun", 32'(ovr_a), 32'(0));
    check("rst_break", 32'(brk_a), 32'(0));
    check("rst_state", 32'(db_a), 32'(0));
    reset = 1'b1;
    repeat (2 * BIT_CLKS) @(posedge clock);
    #1;

    // in-order delivery, no errors
    for (int i = 1; i <= 4; i++) begin
      exp_q_a.push_back({2'b00, 8'(i)});
      send_frame(0, 8'(i), 1'b0, 1'b1);
    end
    wait_drain(0);
    check("count_after_stream", 32'(count_a), 32'(0));
    check("overrun_after_stream", 32'(ovr_a), 32'(0));

    // even parity: bad parity then good parity
    exp_q_b.push_back({2'b10, 8'hA5});
    send_frame(1, 8'hA5, 1'b1, 1'b1);
    exp_q_b.push_back({2'b00, 8'h3C});
    send_frame(1, 8'h3C, 1'b0, 1'b1);
    wait_drain(1);

    // bad stop bit
    exp_q_a.push_back({2'b01, 8'h55});
    send_frame(0, 8'h55, 1'b0, 1'b0);
    wait_drain(0);

    // 10-clock glitch: enters START, then rejects as false start
    drive_bit(0, 1'b0, 10);
    drive_bit(0, 1'b1, 2);
    check("glitch_start", 32'(db_a), 32'(1));
    drive_bit(0, 1'b1, 2 * BIT_CLKS);
    check("glitch_idle", 32'(db_a), 32'(0));
    check("glitch_count", 32'(count_a), 32'(0));

    // overrun with consumer stalled
    ready_a = 1'b0;
    send_frame(0, 8'h11, 1'b0, 1'b1);
    send_frame(0, 8'h22, 1'b0, 1'b1);
    send_frame(0, 8'h33, 1'b0, 1'b1);
    send_frame(0, 8'h44, 1'b0, 1'b1);
    send_frame(0, 8'h55, 1'b0, 1'b1);
    check("full_count", 32'(count_a), 32'(4));
    check("full_overrun", 32'(ovr_a), 32'(1));
    check("full_valid", 32'(valid_a), 32'(1));
    check("full_head", 32'(rd_data_a), 32'h11);
    clr_a = 1'b1;
    @(posedge clock);
    #1;
    clr_a = 1'b0;
    check("clear_overrun", 32'(ovr_a), 32'(0));
    check("clear_keeps_count", 32'(count_a), 32'(4));
    exp_q_a.push_back({2'b00, 8'h11});
    exp_q_a.push_back({2'b00, 8'h22});
    exp_q_a.push_back({2'b00, 8'h33});
    exp_q_a.push_back({2'b00, 8'h44});
    ready_a = 1'b1;
    wait_drain(0);
    check("count_after_drain", 32'(count_a), 32'(0));

    // reset in the middle of 0x77 (during data bit 1, line high)
    drive_bit(0, 1'b0, BIT_CLKS);
    drive_bit(0, 1'b1, BIT_CLKS);
    drive_bit(0, 1'b1, BIT_CLKS / 2);
    check("mid_frame_state", 32'(db_a), 32'(2));
    reset = 1'b0;
    @(posedge clock);
    #1;
    check("mid_reset_state", 32'(db_a), 32'(0));
    check("mid_reset_valid", 32'(valid_a), 32'(0));
    reset = 1'b1;
    drive_bit(0, 1'b1, 3 * BIT_CLKS);
    exp_q_a.push_back({2'b00, 8'h12});
    send_frame(0, 8'h12, 1'b0, 1'b1);
    wait_drain(0);

    // line break of 12 bit times
    if (EXP_BRK == 0) exp_q_a.push_back({2'b01, 8'h00});
    drive_bit(0, 1'b0, 12 * BIT_CLKS);
    drive_bit(0, 1'b1, 3 * BIT_CLKS);
    wait_drain(0);
    check("break_pulses", 32'(n_brk_a), 32'(EXP_BRK));
    check("break_state", 32'(db_a), 32'(0));
    check("break_overrun", 32'(ovr_a), 32'(0));
    exp_q_a.push_back({2'b00, 8'h5A});
    send_frame(0, 8'h5A, 1'b0, 1'b1);
    wait_drain(0);
    check("break_b_quiet", 32'(n_brk_b), 32'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Parametrised UART receiver with oversampled majority-vote sampling, configurable frame format and a first-word-fall-through receive FIFO.
It is the next-generation receive front end for the serial image path: it converts rx_serial into tagged bytes for the image-capture control unit.
Per-byte error tags and an overrun flag let the control unit reject corrupted images without stalling the line.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz
BAUD_RATE, 115200, line rate in bit/s
OVERSAMPLE, 16, sample ticks per bit; even, 8 to 32
DATA_BITS, 8, data bits per frame, 5 to 9, LSB first
PARITY, 0, parity mode: 0 none, 1 odd, 2 even
STOP_BITS, 1, stop bits, 1 or 2
FIFO_DEPTH, 16, receive FIFO entries; power of 2, at least 2

Ports:
clock  in  1  system clock; all logic on its rising edge
reset  in  1  asynchronous, active-low reset
rx_serial  in  1  UART line, idle high; asynchronous to clock
rd_data  out  DATA_BITS  head-of-FIFO data
rd_frame_err  out  1  head byte had a bad stop bit
rd_parity_err  out  1  head byte failed parity; always 0 when PARITY=0
rd_valid  out  1  FIFO not empty
rd_ready  in  1  consumer accepts the head entry
fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy
overrun  out  1  sticky; a completed byte was dropped because the FIFO was full
clear_errors  in  1  synchronous clear of overrun
break_detect  out  1  one-cycle pulse on a line break (see Optional Feature)
db_estado  out  4  current FSM state encoding, for debug

Behaviour:
- Reset, reset low, asynchronous:
  - rd_data=0, rd_frame_err=0, rd_parity_err=0, rd_valid=0, fifo_count=0, overrun=0, break_detect=0.
  - FSM=IDLE, db_estado=0, synchroniser flops=1, tick divider=0.
  - Reset during a frame aborts it. Nothing is pushed and the FIFO is emptied.
- Synchroniser: rx_serial passes through a 2-flop synchroniser to give rxs. All decisions use rxs.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE), integer floor, minimum 1.
  - tick pulses for 1 clock every DIV clocks and free-runs from reset.
- Sampling: each bit is decided by majority of 3 samples taken at ticks OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1 of that bit.
- FSM, db_estado encoding in brackets:
  - IDLE[0]: on a falling edge of rxs, reset the tick count and go to START.
  - START[1]: at the mid-bit decision, 0 goes to DATA and 1 is a false start, returning to IDLE with nothing pushed.
  - DATA[2]: shift DATA_BITS bits in, LSB first. After the last bit go to PARITY if PARITY!=0, else STOP.
  - PARITY[3]: compare the received bit with the computed parity. Odd: XOR of data and parity bit must be 1. Even: it must be 0.
  - STOP[4]: each stop bit must be 1, else frame_err. At the mid-sample of the final stop bit, push and return to IDLE. The receiver resynchronises on the next falling edge.
- FIFO:
  - Each entry holds {parity_err, frame_err, data}.
  - Push happens on the clock after the final stop decision. rd_valid and rd_data are updated on the following edge, so the byte is visible 2 clocks after the decision.
  - Pop occurs when rd_valid and rd_ready are both 1. rd_ready while empty is ignored.
  - Push while full and no pop in the same cycle: byte dropped, overrun=1, contents unchanged.
  - Push and pop in the same cycle while full: both performed, no overrun, count unchanged.
  - Push and pop in the same cycle while empty: not combined. The push is stored and rd_valid rises next cycle.
  - Pointers wrap modulo FIFO_DEPTH. fifo_count ranges 0 to FIFO_DEPTH.
- overrun: cleared by clear_errors. If clear_errors and a new overrun coincide, set wins.

Optional Feature:
UART_RX_BREAK_DETECT_EN
- Defined:
  - A frame whose start bit, data bits, optional parity bit and stop bits all sample 0 is a break.
  - It is not pushed and overrun is unaffected.
  - break_detect pulses 1 clock at the final stop decision.
  - The FSM enters BRKWAIT[5] and returns to IDLE only after rxs=1 for one full bit time.
- Undefined:
  - break_detect is tied to 0 and state 5 does not exist.
  - A break is pushed as data 0 with frame_err=1. The FSM returns to IDLE and waits for the next falling edge.

Test Plan:
- Test parameters: CLK_FREQ=6_400_000, BAUD_RATE=100_000, giving DIV=4 and 64 clocks per bit. 8N1, rd_ready=1.
- Send 0x01, 0x02, 0x03, 0x04 -> read back 0x01, 0x02, 0x03, 0x04 in order, all error flags 0, fifo_count returns to 0.
- PARITY=2: send 0xA5 with the parity bit flipped -> rd_data=0xA5, rd_parity_err=1. Next byte 0x3C correct -> flag 0.
- Send 0x55 with stop bit 0 -> rd_data=0x55, rd_frame_err=1. Low pulse on rx_serial of 10 clocks in IDLE -> false start, nothing pushed.
- FIFO_DEPTH=4, rd_ready=0: send 5 bytes -> fifo_count=4, overrun=1, reads give bytes 1-4. clear_errors -> overrun=0.
- Assert reset for 1 cycle mid-DATA of byte 0x77, then send 0x12 -> only 0x12 received. Break of 12 bit times: with macro, break_detect pulses once and nothing is pushed; without macro, 0x00 is pushed with rd_frame_err=1.
